seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, multi-cycle integer ALU. It is the sequential successor to the combinational add/sub/mul/div selector.
- Same 2-bit Op encoding, same A/B/C operand naming.
- Adds WIDTH generalisation, a valid/ready handshake on both sides, iterative multiply/divide, and divide-by-zero detection.
- Sits between an operand-issuing controller and a result consumer. One operation is in flight at a time.

Parameters:
WIDTH, 32, operand and result width in bits (WIDTH >= 2).
CNT_W, $clog2(WIDTH+1), iteration-counter width (derived; not to be overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operands A, B, Op valid.
in_ready  output  1  block can accept an operation.
A  input  WIDTH  operand A (unsigned).
B  input  WIDTH  operand B (unsigned).
Op  input  2  00 add, 01 sub, 10 mul, 11 div.
out_valid  output  1  C / div_zero valid.
out_ready  input  1  consumer accepts result.
C  output  WIDTH  result.
div_zero  output  1  set with result when Op=11 and B=0.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst: sampled only at the rising edge of clk. It overrides every other input, including mid-operation; an in-flight op is discarded without a result.
- Reset values: state IDLE, out_valid 0, C 0, div_zero 0, internal operand/accumulator/counter registers 0.
- in_ready = (state == IDLE) && !rst. Combinational from state only; no dependency on in_valid.
- Accept: in_valid && in_ready at edge N.
  - A, B and Op are latched.
  - Inputs are don't-care afterwards until the next accept.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accept of add/sub, or of div with B=0.
  - IDLE -> BUSY on accept of mul, or of div with B != 0.
  - BUSY -> DONE when the iteration counter reaches WIDTH.
  - DONE -> IDLE on out_valid && out_ready.
  - No new accept in the same cycle as the result handshake; in_ready rises the cycle after.
- out_valid = (state == DONE).
  - C and div_zero are registered and held stable while out_valid=1 && out_ready=0.
- add: C = (A + B) mod 2^WIDTH. Carry discarded. Latency: out_valid from cycle N+1.
- sub: C = (A - B) mod 2^WIDTH, two's-complement wrap. Latency N+1.
- mul: radix-2 shift-add, one bit of B per cycle, LSB first, WIDTH iterations.
  - C = low WIDTH bits of A*B.
  - out_valid from cycle N+WIDTH+1.
- div: restoring division, one quotient bit per cycle, MSB first, WIDTH iterations.
  - C = floor(A/B). out_valid from cycle N+WIDTH+1.
  - Remainder is kept internally.
- div with B=0: no iteration. C = all ones, div_zero = 1. Latency N+1.
- div_zero = 0 for every other result.
- The iteration counter is CNT_W bits, cleared on accept, and must not wrap.
- Latency is fixed per op, independent of operand values. No early termination.
- out_ready held high from before the result: handshake completes in the first DONE cycle. Block is back in IDLE (in_ready=1) the following cycle.
- out_ready low in IDLE/BUSY: ignored.

Optional Feature:
Macro SEQ_ALU_EXT_RESULT_EN.
- Defined:
  - Adds output port R, WIDTH bits, registered, reset 0, valid with out_valid.
  - mul: R = high WIDTH bits of the 2*WIDTH product.
  - div: R = remainder A mod B.
  - div with B=0: R = A.
  - add: R = carry-out in bit 0, upper bits 0.
  - sub: R = borrow (A < B) in bit 0, upper bits 0.
- Not defined: port R and the extra high-half product register are absent. The product accumulator is WIDTH bits only. All other behaviour is identical.

Test Plan:
- Reset, then add A=0xFFFFFFFF B=0x00000002 (WIDTH=32) -> out_valid at N+1, C=0x00000001, div_zero=0; with _EN, R=0x1.
- sub A=5 B=7 -> C=0xFFFFFFFE at N+1; with _EN, R=0x1.
- mul A=0x00010000 B=0x00030000 -> in_ready=0 for cycles N+1..N+32, out_valid at N+33, C=0x00000000; with _EN, R=0x00000003.
- div A=100 B=7 with out_ready held low 5 cycles after out_valid -> C=14 stable throughout, in_ready=0 until the cycle after the handshake; with _EN, R=2.
- div A=0x1234 B=0 -> out_valid at N+1, C=0xFFFFFFFF, div_zero=1; next op (add 1+1) -> C=2, div_zero=0.
- Start div A=1000 B=3, assert rst at N+10 for one cycle -> out_valid never rises for that op, C=0, in_ready=1 the cycle after rst deasserts; a following add 2+3 -> C=5.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle unsigned integer ALU: add/sub in one cycle, shift-add multiply and restoring divide over WIDTH cycles.
// Optional macro SEQ_ALU_EXT_RESULT_EN adds port R (high product half, remainder, carry or borrow).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             div_zero
`ifdef SEQ_ALU_EXT_RESULT_EN
    ,
    output logic [WIDTH-1:0] R
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_div_r;
    logic [WIDTH-1:0]   c_r;
    logic               dz_r;

    logic [WIDTH-1:0]   a_nxt_s;
    logic [WIDTH-1:0]   b_nxt_s;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic [WIDTH-1:0]   res_c_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;

`ifdef SEQ_ALU_EXT_RESULT_EN
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   res_r_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     add_full_s;
`endif

    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = (state_r == DONE);
    assign C         = c_r;
    assign div_zero  = dz_r;
`ifdef SEQ_ALU_EXT_RESULT_EN
    assign R         = r_r;
`endif

    // One iteration step of the multiply or divide datapath, plus the result it would produce if it were the last.
    always_comb begin
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        div_shift_s = {acc_r, a_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, b_r});
`ifdef SEQ_ALU_EXT_RESULT_EN
        mul_sum_s   = {1'b0, acc_r} + (b_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        add_full_s  = {1'b0, A} + {1'b0, B};
        res_r_s     = '0;
`endif
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        acc_nxt_s   = acc_r;
        res_c_s     = '0;
        if (is_div_r) begin
            // Remainder stays below B, so the shifted trial value minus B always fits WIDTH bits.
            acc_nxt_s = div_ge_s ? WIDTH'(div_shift_s - {1'b0, b_r}) : div_shift_s[WIDTH-1:0];
            a_nxt_s   = {a_r[WIDTH-2:0], div_ge_s};
            res_c_s   = a_nxt_s;
`ifdef SEQ_ALU_EXT_RESULT_EN
            res_r_s   = acc_nxt_s;
`endif
        end else begin
`ifdef SEQ_ALU_EXT_RESULT_EN
            // Full product: high half in acc_r, low half shifts into b_r as multiplier bits retire.
            acc_nxt_s = mul_sum_s[WIDTH:1];
            b_nxt_s   = {mul_sum_s[0], b_r[WIDTH-1:1]};
            res_c_s   = b_nxt_s;
            res_r_s   = acc_nxt_s;
`else
            acc_nxt_s = acc_r + (b_r[0] ? a_r : {WIDTH{1'b0}});
            a_nxt_s   = a_r << 1;
            b_nxt_s   = b_r >> 1;
            res_c_s   = acc_nxt_s;
`endif
        end
    end

    // Control FSM with operand, accumulator, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            is_div_r <= 1'b0;
            c_r      <= '0;
            dz_r     <= 1'b0;
`ifdef SEQ_ALU_EXT_RESULT_EN
            r_r      <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        cnt_r    <= '0;
                        a_r      <= A;
                        b_r      <= B;
                        acc_r    <= '0;
                        is_div_r <= Op[0];
                        dz_r     <= 1'b0;
                        case (Op)
                            2'b00: begin
                                c_r     <= A + B;
`ifdef SEQ_ALU_EXT_RESULT_EN
                                r_r     <= {{(WIDTH-1){1'b0}}, add_full_s[WIDTH]};
`endif
                                state_r <= DONE;
                            end
                            2'b01: begin
                                c_r     <= A - B;
`ifdef SEQ_ALU_EXT_RESULT_EN
                                r_r     <= {{(WIDTH-1){1'b0}}, (A < B)};
`endif
                                state_r <= DONE;
                            end
                            2'b10: begin
                                state_r <= BUSY;
                            end
                            2'b11: begin
                                if (B == '0) begin
                                    c_r     <= '1;
                                    dz_r    <= 1'b1;
`ifdef SEQ_ALU_EXT_RESULT_EN
                                    r_r     <= A;
`endif
                                    state_r <= DONE;
                                end else begin
                                    state_r <= BUSY;
                                end
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    a_r   <= a_nxt_s;
                    b_r   <= b_nxt_s;
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_nxt_s;
                    if (cnt_nxt_s == CNT_W'(WIDTH)) begin
                        c_r     <= res_c_s;
                        dz_r    <= 1'b0;
`ifdef SEQ_ALU_EXT_RESULT_EN
                        r_r     <= res_r_s;
`endif
                        state_r <= DONE;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); checks R too when SEQ_ALU_EXT_RESULT_EN is defined.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    op = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  c;
    logic          div_zero;
`ifdef SEQ_ALU_EXT_RESULT_EN
    logic [W-1:0]  r;
`endif

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .Op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (c),
        .div_zero  (div_zero)
`ifdef SEQ_ALU_EXT_RESULT_EN
        ,
        .R         (r)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one op for a single edge (the accept edge N); returns in cycle N+1.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] iop);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = '0; b = '0; op = 2'b00;
    endtask

    // Issue, confirm no early result, check the result in cycle N+lat, then handshake with out_ready high.
    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [1:0] iop, input int lat, input logic [W-1:0] exp_c,
                          input logic exp_dz, input logic [W-1:0] exp_r);
        int early;
        early = 0;
        out_ready = 1'b1;
        issue(ia, ib, iop);
        for (int i = 1; i < lat; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
            step();
        end
        chk({tag, "_busy_cycles"}, 64'(early), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_c"}, 64'(c), 64'(exp_c));
        chk({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
`ifdef SEQ_ALU_EXT_RESULT_EN
        chk({tag, "_r"}, 64'(r), 64'(exp_r));
`else
        if (exp_r === 'x) $display("unreachable");
`endif
        step();
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_c", 64'(c), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_in_ready_during", 64'(in_ready), 64'd0);
`ifdef SEQ_ALU_EXT_RESULT_EN
        chk("rst_r", 64'(r), 64'd0);
`endif
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", 64'(in_ready), 64'd1);

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0002, 2'b00, 1, 32'h0000_0001, 1'b0, 32'h1);
        run_op("sub_wrap", 32'd5, 32'd7, 2'b01, 1, 32'hFFFF_FFFE, 1'b0, 32'h1);
        run_op("mul_hi", 32'h0001_0000, 32'h0003_0000, 2'b10, 33, 32'h0, 1'b0, 32'h3);
        run_op("mul_small", 32'd7, 32'd6, 2'b10, 33, 32'd42, 1'b0, 32'h0);
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 33, 32'h1, 1'b0, 32'hFFFF_FFFE);
        run_op("div_by_one", 32'hFFFF_FFFF, 32'd1, 2'b11, 33, 32'hFFFF_FFFF, 1'b0, 32'h0);

        // Divide with result stalled by the consumer for 5 cycles.
        out_ready = 1'b0;
        issue(32'd100, 32'd7, 2'b11);
        repeat (31) step();
        chk("div_stall_not_yet", 64'(out_valid), 64'd0);
        step();
        chk("div_stall_valid", 64'(out_valid), 64'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (c !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0 || div_zero !== 1'b0) seen++;
            step();
        end
        chk("div_stall_hold", 64'(seen), 64'd0);
        chk("div_stall_c", 64'(c), 64'd14);
`ifdef SEQ_ALU_EXT_RESULT_EN
        chk("div_stall_r", 64'(r), 64'd2);
`endif
        out_ready = 1'b1;
        chk("div_stall_in_ready_hs", 64'(in_ready), 64'd0);
        step();
        chk("div_stall_out_valid_after", 64'(out_valid), 64'd0);
        chk("div_stall_in_ready_after", 64'(in_ready), 64'd1);

        run_op("div_zero", 32'h0000_1234, 32'h0, 2'b11, 1, 32'hFFFF_FFFF, 1'b1, 32'h0000_1234);
        run_op("add_after_dz", 32'd1, 32'd1, 2'b00, 1, 32'd2, 1'b0, 32'h0);

        // Reset in the middle of a divide: accept at edge N, rst sampled at edge N+10.
        issue(32'd1000, 32'd3, 2'b11);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_c", 64'(c), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        run_op("add_after_rst", 32'd2, 32'd3, 2'b00, 1, 32'd5, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
